// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: RV32 byte/half/word data memory with valid/ready handshake and configurable wait states
module data_memory_ctrl #(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d, ready_q, ready_d, valid_q, valid_d;
  logic [2:0] f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] word, ld, wd;
  logic [15:0] h;
  logic [7:0] b;
  logic [3:0] be;
  logic bad_f3, misal, oor, err, accept, commit;
  always_comb begin
    idx = addr_q[AW+1:2];
    word = mem[idx];
    b = word[8*addr_q[1:0] +: 8];
    h = addr_q[1] ? word[31:16] : word[15:0];
    bad_f3 = we_q ? (f3_q[2] | &f3_q[1:0]) : (&f3_q[1:0] | f3_q == 3'b110);
    misal = (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q == 3'b010 && addr_q[1:0] != 2'b00);
    oor = addr_q[31:AW+2] != '0;
    err = bad_f3 | misal | oor;
    ld = f3_q[1] ? word : f3_q[0] ? {{16{~f3_q[2] & h[15]}}, h} : {{24{~f3_q[2] & b[7]}}, b};
    be = f3_q[1] ? 4'hF : f3_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
    wd = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    accept = state_q == IDLE && req_valid;
    commit = state_q == WAIT && cnt_q == 4'd0;
    state_d = accept ? WAIT : commit ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
    cnt_d = accept ? 4'(LATENCY) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    we_d = accept ? req_we : we_q;
    f3_d = accept ? req_funct3 : f3_q;
    addr_d = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rdata_d = commit ? ((we_q || err) ? 32'd0 : ld) : state_d == IDLE ? 32'd0 : rdata_q;
    err_d = commit ? err : state_d == IDLE ? 1'b0 : err_q;
    ready_d = state_d == IDLE;
    valid_d = state_d == RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  always_ff @(posedge clk)
    if (commit && we_q && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][i*8 +: 8] <= wd[i*8 +: 8];
  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed checks of a LATENCY=2 and a LATENCY=0 controller driven in lockstep
module tb_data_memory_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic rr, rv, re, rr0, rv0, re0;
  logic [31:0] rd, rd0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  data_memory_ctrl #(.DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_rdata(rd), .rsp_err(re));
  data_memory_ctrl #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp, input logic [31:0] exp0,
                     input logic ee, input int hold);
    int lat, lat0;
    @(negedge clk);
    chk({tag, " req_ready"}, {31'd0, rr}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; lat0 = 0;
    while (!rv && lat < 20) begin
      @(posedge clk);
      lat++;
      #1 if (rv0 && lat0 == 0) lat0 = lat;
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " latency0"}, lat0, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, {31'd0, rv}, 32'd1);
      chk({tag, " hold rdata"}, rd, exp);
      chk({tag, " hold ready"}, {31'd0, rr}, 32'd0);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'd0;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " rdata"}, rd, exp);
    chk({tag, " err"}, {31'd0, re}, {31'd0, ee});
    chk({tag, " rdata0"}, rd0, exp0);
    chk({tag, " err0"}, {31'd0, re0}, {31'd0, ee});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, " idle"}, {30'd0, rr, rv}, 32'd2);
    chk({tag, " idle0"}, {30'd0, rr0, rv0}, 32'd2);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset main", {rd[30:0], rr, rv, re}, 34'h4);
    chk("reset rdata", rd, 32'd0);
    chk("reset dut0", {rd0[30:0], rr0, rv0, re0}, 34'h4);
    rst_n = 1'b1;
    txn("SW 10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    txn("LW 10",  0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    txn("SB 11",  1, 3'b000, 32'h11, 32'h000000AA, 0, 0, 0, 0);
    txn("LW 10b", 0, 3'b010, 32'h10, 0, 32'hDEADAAEF, 32'hDEADAAEF, 0, 0);
    txn("LB 11",  0, 3'b000, 32'h11, 0, 32'hFFFFFFAA, 32'hFFFFFFAA, 0, 0);
    txn("LBU 11", 0, 3'b100, 32'h11, 0, 32'h000000AA, 32'h000000AA, 0, 0);
    txn("LH 12",  0, 3'b001, 32'h12, 0, 32'hFFFFDEAD, 32'hFFFFDEAD, 0, 0);
    txn("LHU 12", 0, 3'b101, 32'h12, 0, 32'h0000DEAD, 32'h0000DEAD, 0, 0);
    txn("LBU 10", 0, 3'b100, 32'h10, 0, 32'h000000EF, 32'h000000EF, 0, 0);
    txn("SW 20",  1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, 0, 0);
    txn("LW 13",  0, 3'b010, 32'h13, 0, 0, 0, 1, 0);
    txn("SH 21",  1, 3'b001, 32'h21, 32'h00001234, 0, 0, 1, 0);
    txn("LH 01",  0, 3'b001, 32'h01, 0, 0, 0, 1, 0);
    txn("LW 20",  0, 3'b010, 32'h20, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    txn("LW 400", 0, 3'b010, 32'h400, 0, 0, 0, 1, 0);
    txn("SW 400", 1, 3'b010, 32'h400, 32'h0, 0, 0, 1, 0);
    txn("L 011",  0, 3'b011, 32'h10, 0, 0, 0, 1, 0);
    txn("S 100",  1, 3'b100, 32'h20, 32'h0, 0, 0, 1, 0);
    txn("LW 20b", 0, 3'b010, 32'h20, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    txn("SH 22",  1, 3'b001, 32'h22, 32'hFFFF5555, 0, 0, 0, 0);
    txn("LW 20c", 0, 3'b010, 32'h20, 0, 32'h5555F00D, 32'h5555F00D, 0, 0);
    txn("SW 3FC", 1, 3'b010, 32'h3FC, 32'h0BADF00D, 0, 0, 0, 0);
    txn("LW 3FC", 0, 3'b010, 32'h3FC, 0, 32'h0BADF00D, 32'h0BADF00D, 0, 0);
    txn("LW bp",  0, 3'b010, 32'h10, 0, 32'hDEADAAEF, 32'hDEADAAEF, 0, 5);
    txn("LW 10c", 0, 3'b010, 32'h10, 0, 32'hDEADAAEF, 32'hDEADAAEF, 0, 0);
    txn("SW 40",  1, 3'b010, 32'h40, 32'h11111111, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("pre-reset dut0 valid", {31'd0, rv0}, 32'd1);
    rst_n = 1'b0;
    #1 chk("abort main", {rd[30:0], rr, rv, re}, 34'h4);
    chk("abort rdata", rd, 32'd0);
    chk("abort dut0", {30'd0, rr0, rv0}, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    txn("LW 40", 0, 3'b010, 32'h40, 0, 32'h11111111, 32'h12345678, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
